// File: rtl/mau_pkg.sv
// Shared types and constants for the load/store initiator.
// The lane constants name the byte half of a 16-bit word selected by addr[0].
package mau_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  // Little-endian: lane 0 holds bits [7:0], lane 1 holds bits [15:8].
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    DONE
  } mau_state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane helper: extracts a lane with sign/zero extension and
// merges a byte into a lane of a word, for a 16-bit word.
module byte_lane_merge
  import mau_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] ext_word_i,
  input  logic              ext_lane_i,
  input  logic              ext_signed_i,
  output logic [DATA_W-1:0] ext_data_o,
  input  logic [DATA_W-1:0] mrg_word_i,
  input  logic              mrg_lane_i,
  input  logic [7:0]        mrg_byte_i,
  output logic [DATA_W-1:0] mrg_data_o
);

  logic [7:0] ext_byte;

  always_comb begin
    ext_byte = (ext_lane_i == LANE_HI) ? ext_word_i[15:8] : ext_word_i[7:0];
    ext_data_o = {{(DATA_W-8){ext_signed_i & ext_byte[7]}}, ext_byte};
  end

  always_comb begin
    mrg_data_o = mrg_word_i;
    if (mrg_lane_i == LANE_LO) begin
      mrg_data_o[7:0] = mrg_byte_i;
    end else begin
      mrg_data_o[15:8] = mrg_byte_i;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the datapath and word-organised data memory.
// Handles one byte-addressed access at a time, with read-modify-write for byte stores.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  // Request: accepted in any cycle where req_valid and req_ready are both high.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_dataout
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(2 * MEM_WORDS);

  mau_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_word_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              write_q;
  logic              byte_q;
  logic              signed_q;
  logic              err_q;
  logic              bad_req;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] mrg_data;

  byte_lane_merge #(.DATA_W(DATA_W)) u_lane (
    .ext_word_i   (mem_dataout),
    .ext_lane_i   (addr_q[0]),
    .ext_signed_i (signed_q),
    .ext_data_o   (ext_data),
    .mrg_word_i   (rd_word_q),
    .mrg_lane_i   (addr_q[0]),
    .mrg_byte_i   (wdata_q[7:0]),
    .mrg_data_o   (mrg_data)
  );

  always_comb begin
    bad_req = ({1'b0, req_addr} >= ADDR_LIMIT) || (!req_byte && req_addr[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_word_q    <= '0;
      resp_rdata_q <= '0;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      signed_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            write_q  <= req_write;
            byte_q   <= req_byte;
            signed_q <= req_signed;
            err_q    <= bad_req;
            if (bad_req)         state_q <= DONE;
            else if (!req_write) state_q <= RD;
            else if (!req_byte)  state_q <= WR;
            else                 state_q <= RMW_RD;
          end
        end
        // The load result is registered here so it is already visible in DONE.
        RD: begin
          rd_word_q    <= mem_dataout;
          resp_rdata_q <= byte_q ? ext_data : mem_dataout;
          state_q      <= DONE;
        end
        WR:      state_q <= DONE;
        RMW_RD: begin
          rd_word_q <= mem_dataout;
          state_q   <= RMW_WR;
        end
        RMW_WR:  state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst_n so a reset cycle never issues a memory access.
  always_comb begin
    req_ready    = (state_q == IDLE);
    resp_valid   = rst_n && (state_q == DONE);
    resp_err     = resp_valid && err_q;
    resp_rdata   = resp_rdata_q;
    mem_address  = {1'b0, addr_q[ADDR_W-1:1]};
    mem_memread  = rst_n && ((state_q == RD) || (state_q == RMW_RD));
    mem_memwrite = rst_n && ((state_q == WR) || (state_q == RMW_WR));
    mem_datain   = '0;
    if (mem_memwrite) begin
      mem_datain = (state_q == RMW_WR) ? mrg_data : wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a small word memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [15:0] resp_rdata;
  logic [15:0] mem_address;
  logic [15:0] mem_datain;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [15:0] mem_dataout;

  logic [15:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [15:0] bd_val;

  int vecs = 0;
  int miss = 0;

  int          r_lat, r_nrd, r_nwr, r_nresp;
  logic        r_err, r_busy_bad, r_both, r_dz;
  logic [15:0] r_rdata, r_addr;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_byte     (req_byte),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_address  (mem_address),
    .mem_datain   (mem_datain),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .mem_dataout  (mem_dataout)
  );

  // Clock and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dataout = (mem_address < 16'd256) ? mem[mem_address[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (mem_memwrite) begin
      if (mem_address < 16'd256) mem[mem_address[7:0]] <= mem_datain;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_val;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [15:0] val);
    @(negedge clk);
    bd_we  = 1'b1;
    bd_idx = idx;
    bd_val = val;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  // Issue one request and observe five cycles after the accept edge.
  task automatic run(input logic w, input logic b, input logic s,
                     input logic [15:0] addr, input logic [15:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_byte   = b;
    req_signed = s;
    req_addr   = addr;
    req_wdata  = wd;
    r_lat = 0; r_nrd = 0; r_nwr = 0; r_nresp = 0;
    r_err = 1'b0; r_busy_bad = 1'b0; r_both = 1'b0; r_dz = 1'b0;
    r_rdata = 16'h0; r_addr = 16'h0;
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_memread) r_nrd++;
      if (mem_memwrite) r_nwr++;
      if (mem_memread || mem_memwrite) r_addr = mem_address;
      if (mem_memread && mem_memwrite) r_both = 1'b1;
      if (!mem_memwrite && mem_datain !== 16'h0) r_dz = 1'b1;
      if (resp_valid) begin
        r_nresp++;
        if (r_lat == 0) begin
          r_lat   = k;
          r_err   = resp_err;
          r_rdata = resp_rdata;
        end
      end
      if ((r_lat == 0 || r_lat == k) && req_ready) r_busy_bad = 1'b1;
    end
  endtask

  task automatic check_txn(input string tag, input int lat, input logic err,
                           input logic [15:0] rdata, input int nrd, input int nwr,
                           input logic [15:0] addr);
    chk({tag, "_lat"},   32'(r_lat), 32'(lat));
    chk({tag, "_err"},   32'(r_err), 32'(err));
    chk({tag, "_rdata"}, 32'(r_rdata), 32'(rdata));
    chk({tag, "_nrd"},   32'(r_nrd), 32'(nrd));
    chk({tag, "_nwr"},   32'(r_nwr), 32'(nwr));
    chk({tag, "_nresp"}, 32'(r_nresp), 32'd1);
    chk({tag, "_busy"},  32'(r_busy_bad), 32'd0);
    chk({tag, "_both"},  32'(r_both), 32'd0);
    chk({tag, "_dz"},    32'(r_dz), 32'd0);
    if (nrd + nwr > 0) chk({tag, "_addr"}, 32'(r_addr), 32'(addr));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_signed = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    bd_we = 1'b0; bd_idx = 8'h0; bd_val = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",    32'(req_ready), 32'd1);
    chk("rst_rvalid",   32'(resp_valid), 32'd0);
    chk("rst_rerr",     32'(resp_err), 32'd0);
    chk("rst_rdata",    32'(resp_rdata), 32'd0);
    chk("rst_maddr",    32'(mem_address), 32'd0);
    chk("rst_mdatain",  32'(mem_datain), 32'd0);
    chk("rst_mread",    32'(mem_memread), 32'd0);
    chk("rst_mwrite",   32'(mem_memwrite), 32'd0);
    rst_n = 1'b1;

    poke(8'd5, 16'h1234);
    run(1'b0, 1'b0, 1'b0, 16'h000A, 16'h0);
    check_txn("ldw_0a", 2, 1'b0, 16'h1234, 1, 0, 16'd5);

    run(1'b1, 1'b0, 1'b0, 16'h0004, 16'hBEEF);
    check_txn("stw_04", 2, 1'b0, 16'h1234, 0, 1, 16'd2);
    chk("stw_04_mem", 32'(mem[2]), 32'h0000BEEF);

    poke(8'd3, 16'hAABB);
    run(1'b1, 1'b1, 1'b0, 16'h0007, 16'h00CC);
    check_txn("stb_07", 3, 1'b0, 16'h1234, 1, 1, 16'd3);
    chk("stb_07_mem", 32'(mem[3]), 32'h0000CCBB);

    poke(8'd3, 16'hAA11);
    run(1'b1, 1'b1, 1'b0, 16'h0006, 16'hFF22);
    check_txn("stb_06", 3, 1'b0, 16'h1234, 1, 1, 16'd3);
    chk("stb_06_mem", 32'(mem[3]), 32'h0000AA22);

    poke(8'd3, 16'h80FF);
    run(1'b0, 1'b1, 1'b1, 16'h0007, 16'h0);
    check_txn("ldbs_07", 2, 1'b0, 16'hFF80, 1, 0, 16'd3);
    run(1'b0, 1'b1, 1'b0, 16'h0006, 16'h0);
    check_txn("ldbu_06", 2, 1'b0, 16'h00FF, 1, 0, 16'd3);
    run(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0);
    check_txn("ldbu_07", 2, 1'b0, 16'h0080, 1, 0, 16'd3);
    run(1'b0, 1'b1, 1'b1, 16'h0006, 16'h0);
    check_txn("ldbs_06", 2, 1'b0, 16'hFFFF, 1, 0, 16'd3);

    run(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0);
    check_txn("err_mis", 1, 1'b1, 16'hFFFF, 0, 0, 16'd0);
    run(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0);
    check_txn("err_ldb_200", 1, 1'b1, 16'hFFFF, 0, 0, 16'd0);
    run(1'b1, 1'b0, 1'b0, 16'h0200, 16'h5555);
    check_txn("err_stw_200", 1, 1'b1, 16'hFFFF, 0, 0, 16'd0);
    run(1'b0, 1'b0, 1'b0, 16'h01FF, 16'h0);
    check_txn("err_mis_1ff", 1, 1'b1, 16'hFFFF, 0, 0, 16'd0);

    poke(8'd255, 16'h7A00);
    run(1'b0, 1'b1, 1'b0, 16'h01FF, 16'h0);
    check_txn("ldb_1ff", 2, 1'b0, 16'h007A, 1, 0, 16'd255);
    run(1'b0, 1'b0, 1'b0, 16'h01FE, 16'h0);
    check_txn("ldw_1fe", 2, 1'b0, 16'h7A00, 1, 0, 16'd255);

    // Reset in the write half of a byte store must drop the write and the response.
    poke(8'd3, 16'hAABB);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
    req_addr = 16'h0007; req_wdata = 16'h00CC;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmwrst_rd", 32'(mem_memread), 32'd1);
    @(negedge clk);
    chk("rmwrst_wr_pre", 32'(mem_memwrite), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmwrst_wr_gated", 32'(mem_memwrite), 32'd0);
    chk("rmwrst_din_zero", 32'(mem_datain), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rmwrst_ready", 32'(req_ready), 32'd1);
    chk("rmwrst_mem", 32'(mem[3]), 32'h0000AABB);
    chk("rmwrst_rdata", 32'(resp_rdata), 32'd0);
    r_nresp = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) r_nresp++;
      @(negedge clk);
    end
    chk("rmwrst_nresp", 32'(r_nresp), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the multicycle 16-bit RISC processor. It sits between the control unit/datapath and the word-organised data memory. It accepts one byte-addressed load or store request at a time and drives the memory's `address`/`datain`/`memread`/`memwrite` pins, performing read-modify-write for byte stores. It returns a registered, optionally sign-extended result with a one-cycle response pulse.

## Interface
Parameters:
- `DATA_W`, 16, data word width.
- `ADDR_W`, 16, request and memory address width.
- `MEM_WORDS`, 256, number of memory words; byte addresses at or above `2*MEM_WORDS` are errors.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  1 = byte access, 0 = word access.
- `req_signed`  in  1  sign-extend byte loads; ignored otherwise.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data; byte stores use `[7:0]`.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  qualifies `resp_valid`: misaligned or out-of-range access.
- `resp_rdata`  out  DATA_W  load result; holds until the next load completes.
- `mem_address`  out  ADDR_W  word index to memory (`req_addr >> 1`).
- `mem_datain`  out  DATA_W  write data to memory.
- `mem_memread`  out  1  memory read strobe.
- `mem_memwrite`  out  1  memory write strobe; memory commits it on the rising edge.
- `mem_dataout`  in  DATA_W  combinational read data from memory.

## Operation
- States: `IDLE`, `RD`, `WR`, `RMW_RD`, `RMW_WR`, `DONE`.
- `IDLE`:
  - `req_ready=1`.
  - On `req_valid`, latch all request fields and move on.
  - Out-of-range address, or word access with `addr[0]=1`: go to `DONE` with error flag set.
  - Otherwise the next state is:
    - word or byte load: `RD`;
    - word store: `WR`;
    - byte store: `RMW_RD`.
- `RD`: `mem_memread=1`. Capture `mem_dataout` into the read register, then go to `DONE`.
- `WR`: `mem_memwrite=1`, `mem_datain` = latched wdata, then go to `DONE`.
- `RMW_RD`: `mem_memread=1`. Capture the word, then go to `RMW_WR`.
- `RMW_WR`: `mem_memwrite=1`.
  - `mem_datain` = captured word with lane `addr[0]` replaced by `wdata[7:0]`.
  - Lane 0 = bits `[7:0]` (little-endian).
  - Then go to `DONE`.
- `DONE`:
  - `resp_valid=1` and `resp_err` = error flag.
  - For loads, `resp_rdata` is loaded in this cycle:
    - word loads return the full word;
    - byte loads return the selected lane, zero- or sign-extended per `req_signed`.
  - Stores and errors leave `resp_rdata` unchanged.
  - Return to `IDLE`.
- `mem_memread` and `mem_memwrite` are never both 1.
- Errors never assert either strobe.
- `mem_address` is held stable from the first strobe cycle through `DONE`.
- `mem_datain` is 0 whenever `mem_memwrite=0`.
- Strobes are decoded from state and gated by `rst_n`: no read or write is issued in any cycle with `rst_n=0`.

## Timing
- Reset (rising edge with `rst_n=0`):
  - state `IDLE`, so `req_ready=1`;
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`;
  - `mem_address=0`, `mem_datain=0`, `mem_memread=0`, `mem_memwrite=0`.
- Accept cycle T (`req_valid & req_ready`):
  - word/byte load: `RD` at T+1, `resp_valid` at T+2;
  - word store: write commits at the end of T+1, `resp_valid` at T+2;
  - byte store: read at T+1, write at T+2, `resp_valid` at T+3;
  - error: `resp_valid`/`resp_err` at T+1.
- `req_ready=0` from T+1 until the unit returns to `IDLE`; the next accept is possible the cycle after `DONE`.
- A request held on `req_valid` during busy cycles is ignored until `IDLE`.
- Reset mid-operation abandons the access. A pending write is not committed, because `mem_memwrite` is gated low while `rst_n=0`, and no `resp_valid` is issued.
- Address `2*MEM_WORDS-1` is valid; `2*MEM_WORDS` is an error. There is no wrap-around.

## Structure
- Package `mau_pkg` holds:
  - the `mau_state_t` enum (six states);
  - `DATA_W`/`ADDR_W` defaults;
  - the lane-select constants.
- Sub-module `byte_lane_merge` (combinational) provides two functions:
  - extract: lane + sign/zero-extend;
  - merge: replace a lane in a word.
- The top level contains the FSM, the request latch and the read register.

## Test plan
- Memory word 5 = `0x1234`. Word load from byte addr `0x000A` -> `resp_rdata=0x1234` at T+2, `resp_err=0`, one `mem_memread` cycle with `mem_address=5`.
- Word store `0xBEEF` to addr `0x0004` -> single `mem_memwrite` at T+1; memory word 2 = `0xBEEF`; `resp_valid` at T+2.
- Word 3 = `0xAABB`. Byte store `0xCC` to addr `0x0007` -> word 3 = `0xCCBB`, `resp_valid` at T+3.
- Word 3 = `0x80FF`:
  - signed byte load from addr `0x0007` -> `0xFF80`;
  - unsigned byte load from addr `0x0006` -> `0x00FF`.
- Error cases, each with no strobes and `resp_err=1` at T+1:
  - word load from addr `0x0003`;
  - any access to addr `0x0200`.
- Byte store accepted, `rst_n=0` during the `RMW_WR` cycle -> memory unchanged, no `resp_valid`, `req_ready=1` after the reset edge.
